alu_sequencer: RTL and testbench
================================

ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter N, default 32, meaning operand width in bits; Result is 2N bits.
REQ-002 SHALL have port Clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port Reset, input, 1, reset that is synchronous and active-high.
REQ-004 SHALL have port InValid, input, 1, request present.
REQ-005 SHALL have port InReady, output, 1, request may be accepted this cycle.
REQ-006 SHALL have ports A and B, input, N each, unsigned operands.
REQ-007 SHALL have port Sel, input, 2, operation: 0 add, 1 subtract, 2 multiply, 3 divide.
REQ-008 SHALL have port OutValid, output, 1, Result valid.
REQ-009 SHALL have port OutReady, input, 1, consumer takes Result.
REQ-010 SHALL have port Result, output, 2N, operation result.
REQ-011 SHALL have port DivByZero, output, 1, qualifies Result for a divide with B==0.
REQ-012 SHALL have port Busy, output, 1, high in any state other than IDLE.

Function
REQ-013 SHALL accept a request in a cycle where InValid and InReady are both high, capturing A, B and Sel in that cycle. Later input changes SHALL be ignored until the next acceptance.
REQ-014 SHALL drive InReady high only in IDLE, so at most one operation is in flight.
REQ-015 SHALL use states IDLE, ADDSUB, MUL, DIV and DONE.
- IDLE, on accept: Sel 0/1 -> ADDSUB; Sel 2 -> MUL; Sel 3 -> DIV.
- ADDSUB -> DONE after 1 cycle.
- MUL and DIV -> DONE after exactly N iteration cycles, counted by a counter running 0..N-1.
- DONE -> IDLE in a cycle where OutReady is high.
REQ-016 SHALL raise OutValid in DONE only; first OutValid cycle is acceptance +2 for add/sub and acceptance +N+1 for mul/div.
REQ-017 SHALL hold Result and DivByZero stable while OutValid is high and OutReady is low; the output handshake completes when OutValid and OutReady are both high.
REQ-018 SHALL produce add Result as {zero pad, carry-out, A+B[N-1:0]}, i.e. N+1 significant bits.
REQ-019 SHALL produce subtract Result as {zero pad, carry-out, A-B[N-1:0]}. The subtract is computed as A+~B+1, so carry-out is 1 when A>=B.
REQ-020 SHALL produce multiply Result as the full 2N-bit unsigned product, computed by shift-add with one bit of B per iteration cycle, LSB first.
REQ-021 SHALL produce divide Result as {remainder, quotient} by restoring division, one quotient bit per iteration cycle, MSB first.
REQ-022 SHALL handle a divide with B==0 by running the full N cycles, then returning quotient all ones and remainder = A, with DivByZero high.
REQ-023 SHALL hold DivByZero low for every other result.
REQ-024 SHALL drive Result to zero in IDLE.

Reset
REQ-025 SHALL, while Reset is high at a clock edge, go to IDLE and clear the counter, operand and accumulator registers, Result and DivByZero.
REQ-026 SHALL drive OutValid low, Busy low and InReady high from the cycle after Reset is sampled.
REQ-027 SHALL, when Reset occurs mid-operation (including in DONE with OutValid high), abandon the operation with no output handshake; Reset SHALL take priority over any simultaneous accept.

Structure
REQ-028 SHALL place the state enum, the Sel opcode constants (OP_ADD, OP_SUB, OP_MUL, OP_DIV) and the default N in shared package alu_seq_pkg.
REQ-029 SHALL instantiate one sub-module, alu_iter_step: combinational single-iteration shift-add / shift-subtract-restore step, selected by operation.

Verification
REQ-030 SHALL cover: Sel=0, A=10, B=30 -> Result=40 with OutValid at acceptance+2 and DivByZero=0.
REQ-031 SHALL cover: Sel=1, A=10, B=30 -> Result=0x0_FFFFFFEC (carry-out 0); then A=30, B=10 -> Result=0x1_00000014.
REQ-032 SHALL cover: Sel=2, A=B=0xFFFFFFFF -> Result=0xFFFFFFFE_00000001 at acceptance+33; InReady low in cycles +1 to +33.
REQ-033 SHALL cover: Sel=3, A=30, B=7 -> Result=0x00000002_00000004; then A=7, B=0 -> Result=0x00000007_FFFFFFFF with DivByZero=1.
REQ-034 SHALL cover: OutReady held low 5 cycles in DONE -> Result stable and InReady low throughout; OutReady high -> IDLE next cycle.
REQ-035 SHALL cover: Reset pulsed at iteration 10 of a divide -> OutValid never rises for it; a following add of 1+1 returns 2 normally.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the ALU sequencer: FSM state encoding, Sel opcode
// constants and the default operand width.
package alu_seq_pkg;

    localparam int N_DEFAULT = 32;

    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_MUL = 2'd2;
    localparam logic [1:0] OP_DIV = 2'd3;

    typedef enum logic [2:0] {
        IDLE,
        ADDSUB,
        MUL,
        DIV,
        DONE
    } state_e;

endpackage

// File: rtl/alu_iter_step.sv
// One combinational iteration of the multi-cycle multiply / divide.
//   op_div_i : 0 = shift-add multiply step, 1 = restoring divide step
//   acc_i    : 2N-bit accumulator
//              multiply: {partial product high, remaining multiplier bits}
//              divide  : {partial remainder, remaining dividend / quotient}
//   a_i      : multiplicand (multiply only)
//   b_i      : divisor (divide only)
//   acc_o    : accumulator after this iteration
module alu_iter_step
    import alu_seq_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           op_div_i,
    input  logic [2*N-1:0] acc_i,
    input  logic [N-1:0]   a_i,
    input  logic [N-1:0]   b_i,
    output logic [2*N-1:0] acc_o
);

    logic [N:0]   mul_sum;
    logic [N:0]   div_shift;
    logic [N-1:0] div_rem;
    logic         div_fits;

    always_comb begin
        // Multiply: add the multiplicand when the current multiplier LSB is
        // set, then shift the whole accumulator right by one (the carry
        // becomes the new MSB).
        mul_sum = {1'b0, acc_i[2*N-1:N]} + {1'b0, (acc_i[0] ? a_i : {N{1'b0}})};

        // Divide: shift the next dividend bit into the remainder; subtract
        // the divisor only if it fits, otherwise keep (restore) the shifted
        // value. The quotient bit enters at the LSB.
        div_shift = {acc_i[2*N-1:N], acc_i[N-1]};
        div_fits  = (div_shift >= {1'b0, b_i});
        div_rem   = div_shift[N-1:0] - b_i;

        if (op_div_i) begin
            acc_o = {(div_fits ? div_rem : div_shift[N-1:0]), acc_i[N-2:0], div_fits};
        end else begin
            acc_o = {mul_sum, acc_i[N-1:1]};
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Multi-cycle ALU with valid/ready handshakes on both sides.
//   Clk, Reset          : clock and synchronous active-high reset
//   InValid / InReady   : request handshake; A, B, Sel captured on accept
//   A, B                : N-bit unsigned operands
//   Sel                 : 0 add, 1 subtract, 2 multiply, 3 divide
//   OutValid / OutReady : result handshake
//   Result              : 2N-bit result (zero while idle)
//   DivByZero           : qualifies a divide result with B == 0
//   Busy                : high whenever the FSM is not IDLE
// Add/sub take one cycle; multiply/divide iterate N cycles through
// alu_iter_step.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N = N_DEFAULT
) (
    input  logic           Clk,
    input  logic           Reset,
    input  logic           InValid,
    output logic           InReady,
    input  logic [N-1:0]   A,
    input  logic [N-1:0]   B,
    input  logic [1:0]     Sel,
    output logic           OutValid,
    input  logic           OutReady,
    output logic [2*N-1:0] Result,
    output logic           DivByZero,
    output logic           Busy
);

    localparam int CW = (N > 1) ? $clog2(N) : 1;

    state_e         state_q, state_d;
    logic [CW-1:0]  cnt_q;
    logic [N-1:0]   a_q, b_q;
    logic [1:0]     op_q;
    logic [2*N-1:0] acc_q;
    logic [2*N-1:0] result_q;
    logic           dbz_q;

    logic           accept;
    logic           cnt_last;
    logic [N:0]     addsub;
    logic [2*N-1:0] acc_next;

    assign accept   = InValid && (state_q == IDLE);
    assign cnt_last = (cnt_q == CW'(N - 1));

    // Subtract as A + ~B + 1 so bit N is the carry-out (1 when A >= B).
    always_comb begin
        if (op_q == OP_SUB) begin
            addsub = {1'b0, a_q} + {1'b0, ~b_q} + {{N{1'b0}}, 1'b1};
        end else begin
            addsub = {1'b0, a_q} + {1'b0, b_q};
        end
    end

    alu_iter_step #(.N(N)) u_step (
        .op_div_i (state_q == DIV),
        .acc_i    (acc_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .acc_o    (acc_next)
    );

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d  = state_q;
        InReady  = 1'b0;
        OutValid = 1'b0;
        Busy     = 1'b1;
        case (state_q)
            IDLE: begin
                InReady = 1'b1;
                Busy    = 1'b0;
                if (InValid) begin
                    if (Sel == OP_MUL)      state_d = MUL;
                    else if (Sel == OP_DIV) state_d = DIV;
                    else                    state_d = ADDSUB;
                end
            end
            ADDSUB:   state_d = DONE;
            MUL, DIV: if (cnt_last) state_d = DONE;
            DONE: begin
                OutValid = 1'b1;
                if (OutReady) state_d = IDLE;
            end
            default:  state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge Clk) begin
        if (Reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: the block holds no RAM, so every datapath register is reset;
    // this also drops any half-finished operation.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            op_q     <= OP_ADD;
            acc_q    <= '0;
            result_q <= '0;
            dbz_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_q   <= A;
                        b_q   <= B;
                        op_q  <= Sel;
                        cnt_q <= '0;
                        // Divide iterates over the dividend, multiply over B.
                        acc_q <= (Sel == OP_DIV) ? {{N{1'b0}}, A} : {{N{1'b0}}, B};
                    end
                end
                ADDSUB: begin
                    result_q <= {{(N-1){1'b0}}, addsub};
                    dbz_q    <= 1'b0;
                end
                MUL, DIV: begin
                    acc_q <= acc_next;
                    cnt_q <= cnt_q + CW'(1);
                    if (cnt_last) begin
                        result_q <= acc_next;
                        // A zero divisor naturally yields all-ones quotient
                        // and remainder = A; only the flag needs setting.
                        dbz_q    <= (state_q == DIV) && (b_q == '0);
                    end
                end
                default: ;
            endcase
        end
    end

    assign Result    = (state_q == DONE) ? result_q : '0;
    assign DivByZero = (state_q == DONE) && dbz_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: expected results are queued when a
// request is accepted and compared when the output handshake completes.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int N = 32;

    logic           Clk = 1'b0;
    logic           Reset;
    logic           InValid;
    logic           InReady;
    logic [N-1:0]   A, B;
    logic [1:0]     Sel;
    logic           OutValid;
    logic           OutReady;
    logic [2*N-1:0] Result;
    logic           DivByZero;
    logic           Busy;

    alu_sequencer #(.N(N)) dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .InValid   (InValid),
        .InReady   (InReady),
        .A         (A),
        .B         (B),
        .Sel       (Sel),
        .OutValid  (OutValid),
        .OutReady  (OutReady),
        .Result    (Result),
        .DivByZero (DivByZero),
        .Busy      (Busy)
    );

    always #5 Clk = ~Clk;

    int cyc = 0;
    always @(posedge Clk) cyc <= cyc + 1;

    typedef struct packed {
        logic [2*N-1:0] res;
        logic           dbz;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [1:0] sel, input logic [N-1:0] a, input logic [N-1:0] b);
        exp_t m;
        logic [N:0] s;
        m.dbz = 1'b0;
        m.res = '0;
        case (sel)
            OP_ADD: begin
                s     = {1'b0, a} + {1'b0, b};
                m.res = {{(N-1){1'b0}}, s};
            end
            OP_SUB: begin
                s     = {(a >= b), N'(a - b)};
                m.res = {{(N-1){1'b0}}, s};
            end
            OP_MUL: m.res = (2*N)'(a) * (2*N)'(b);
            default: begin
                if (b == '0) begin
                    m.res = {a, {N{1'b1}}};
                    m.dbz = 1'b1;
                end else begin
                    m.res = {N'(a % b), N'(a / b)};
                end
            end
        endcase
        return m;
    endfunction

    // Scoreboard: a handshake completes at the next rising edge when both
    // OutValid and OutReady are high; sample just after the falling edge.
    always @(negedge Clk) begin
        #1;
        if (OutValid && OutReady && !Reset) begin
            if (sb_q.size() == 0) begin
                check("unexpected_output", 64'(OutValid), 64'd0);
            end else begin
                mon_e = sb_q.pop_front();
                check("result", 64'(Result), 64'(mon_e.res));
                check("div_by_zero", 64'(DivByZero), 64'(mon_e.dbz));
            end
        end
    end

    task automatic run_op(input logic [1:0] sel, input logic [N-1:0] a, input logic [N-1:0] b,
                          input int hold, input string name);
        int             acc_cyc, waited, bad_ready, bad_busy, exp_lat;
        logic [2*N-1:0] r0;
        exp_lat = (sel == OP_MUL || sel == OP_DIV) ? N + 1 : 2;
        @(negedge Clk);
        Sel = sel; A = a; B = b; InValid = 1'b1;
        waited = 0;
        while (!InReady && waited < 50) begin
            @(negedge Clk);
            waited++;
        end
        check({name, "_accept"}, 64'(InReady), 64'd1);
        acc_cyc = cyc;
        sb_q.push_back(model(sel, a, b));
        @(negedge Clk);
        // Scramble inputs: the captured operands must be used.
        InValid = 1'b0; A = $urandom; B = $urandom; Sel = 2'($urandom);
        waited = 0; bad_ready = 0; bad_busy = 0;
        while (!OutValid && waited < 100) begin
            if (InReady) bad_ready++;
            if (!Busy)   bad_busy++;
            @(negedge Clk);
            waited++;
        end
        check({name, "_outvalid"}, 64'(OutValid), 64'd1);
        check({name, "_latency"}, 64'(cyc - acc_cyc), 64'(exp_lat));
        check({name, "_inready_low"}, 64'(bad_ready), 64'd0);
        check({name, "_busy_high"}, 64'(bad_busy), 64'd0);
        r0 = Result;
        for (int i = 0; i < hold; i++) begin
            @(negedge Clk);
            check({name, "_hold_result"}, 64'(Result), 64'(r0));
            check({name, "_hold_inready"}, 64'(InReady), 64'd0);
            check({name, "_hold_outvalid"}, 64'(OutValid), 64'd1);
        end
        OutReady = 1'b1;
        @(negedge Clk);
        OutReady = 1'b0;
        check({name, "_idle_inready"}, 64'(InReady), 64'd1);
        check({name, "_idle_outvalid"}, 64'(OutValid), 64'd0);
        check({name, "_idle_result"}, 64'(Result), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc_cyc, waited, ov_seen;
        Reset = 1'b1; InValid = 1'b0; OutReady = 1'b0;
        A = '0; B = '0; Sel = OP_ADD;
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        @(negedge Clk);
        check("rst_inready", 64'(InReady), 64'd1);
        check("rst_busy", 64'(Busy), 64'd0);
        check("rst_outvalid", 64'(OutValid), 64'd0);
        check("rst_result", 64'(Result), 64'd0);
        check("rst_dbz", 64'(DivByZero), 64'd0);

        run_op(OP_ADD, 32'd10, 32'd30, 0, "add_10_30");
        run_op(OP_SUB, 32'd10, 32'd30, 0, "sub_10_30");
        run_op(OP_SUB, 32'd30, 32'd10, 0, "sub_30_10");
        run_op(OP_MUL, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, "mul_max");
        run_op(OP_DIV, 32'd30, 32'd7, 0, "div_30_7");
        run_op(OP_DIV, 32'd7, 32'd0, 0, "div_by_zero");
        run_op(OP_MUL, 32'd12345, 32'd6789, 5, "mul_hold");
        run_op(OP_ADD, 32'hFFFF_FFFF, 32'd1, 0, "add_carry");
        run_op(OP_DIV, 32'hFFFF_FFFF, 32'd1, 0, "div_by_one");
        for (int i = 0; i < 8; i++) begin
            run_op(2'($urandom), $urandom, $urandom_range(0, 3) == 0 ? 32'($urandom_range(0, 5)) : 32'($urandom),
                   i % 3, "random");
        end

        // Abort a divide at iteration 10 with a one-cycle reset pulse.
        @(negedge Clk);
        Sel = OP_DIV; A = 32'd100; B = 32'd3; InValid = 1'b1;
        waited = 0;
        while (!InReady && waited < 50) begin
            @(negedge Clk);
            waited++;
        end
        check("abort_accept", 64'(InReady), 64'd1);
        acc_cyc = cyc;
        @(negedge Clk);
        InValid = 1'b0;
        repeat (10) @(negedge Clk);
        check("abort_iter10_cycle", 64'(cyc - acc_cyc), 64'd11);
        check("abort_busy_before", 64'(Busy), 64'd1);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        check("abort_inready", 64'(InReady), 64'd1);
        check("abort_busy", 64'(Busy), 64'd0);
        check("abort_outvalid", 64'(OutValid), 64'd0);
        check("abort_result", 64'(Result), 64'd0);
        ov_seen = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge Clk);
            if (OutValid) ov_seen++;
        end
        check("abort_no_outvalid", 64'(ov_seen), 64'd0);
        run_op(OP_ADD, 32'd1, 32'd1, 0, "add_after_abort");

        check("scoreboard_empty", 64'(sb_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
